mc_drain_arbiter: RTL



---
 rtl/drain_pkg.sv | 43 ++++
 rtl/mc_drain_arbiter_if.sv | 32 +++
 rtl/drain_out_buf.sv | 55 +++++
 rtl/mc_drain_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/drain_pkg.sv
// Shared types and helpers for the multichannel drain arbiter.
//   state_t        : arbiter FSM states
//   OUT_BUF_DEPTH  : depth of the output skid buffer; also the read credit limit
//   rr_next()      : round-robin pick of the first requester at or after a pointer
// The output word struct depends on module parameters, so each module declares
// its own out_word_t from its local widths.
package drain_pkg;

  typedef enum logic [0:0] {
    ARB,
    BURST
  } state_t;

  localparam int unsigned OUT_BUF_DEPTH = 4;
  localparam int unsigned OCC_W         = $clog2(OUT_BUF_DEPTH + 1);
  localparam int unsigned PTR_W         = $clog2(OUT_BUF_DEPTH);

  // Widest request vector rr_next() can scan.
  localparam int unsigned MAX_CH   = 32;
  localparam int unsigned MAX_CH_W = $clog2(MAX_CH);

  // First set bit of req[n-1:0] scanning upward from ptr with wrap; returns ptr
  // when nothing requests. ptr must be < n.
  function automatic int unsigned rr_next(input int unsigned      ptr,
                                          input logic [MAX_CH-1:0] req,
                                          input int unsigned      n);
    int unsigned idx;
    logic        found;
    rr_next = ptr;
    found   = 1'b0;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[MAX_CH_W-1:0]]) begin
          rr_next = idx;
          found   = 1'b1;
        end
      end
    end
  endfunction

endpackage

// File: rtl/mc_drain_arbiter_if.sv
// Bundle between the drain arbiter, the channel FIFOs and the downstream sink.
//   FIFO side : ch_empty, ch_usedw, ch_data (in to arbiter), ch_rd_en (out)
//   Stream    : m_valid, m_data, m_chan, m_last (out), m_ready (in)
// master = the arbiter, slave = the FIFOs plus downstream consumer.
interface mc_drain_arbiter_if #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]            ch_empty;
  logic [NUM_CH*UW-1:0]         ch_usedw;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_rd_en;
  logic                         m_valid;
  logic                         m_ready;
  logic [DATA_WIDTH-1:0]        m_data;
  logic [CW-1:0]                m_chan;
  logic                         m_last;

  modport master (
    input  ch_empty, ch_usedw, ch_data, m_ready,
    output ch_rd_en, m_valid, m_data, m_chan, m_last
  );

  modport slave (
    output ch_empty, ch_usedw, ch_data, m_ready,
    input  ch_rd_en, m_valid, m_data, m_chan, m_last
  );
endinterface

// File: rtl/drain_out_buf.sv
// Small FIFO holding packed {data, chan, last} words between the FIFO read
// pipeline and the output stream. Head is driven straight from storage, so a
// word pushed at the end of cycle t is presented in cycle t+1.
//   clk, reset       : clock, synchronous active-high reset
//   push, push_word  : write strobe and word
//   pop              : consume head (ignored while empty)
//   occ, valid, head : occupancy, non-empty flag, head word (zero when empty)
module drain_out_buf
  import drain_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_word,
  input  logic             pop,
  output logic [OCC_W-1:0] occ,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem_q [OUT_BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0] occ_q;
  logic             do_pop;

  assign valid  = (occ_q != '0);
  assign do_pop = pop && valid;
  assign occ    = occ_q;
  // Zeroed while empty so the stream shows clean values when idle.
  assign head   = valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !do_pop)      occ_q <= occ_q + 1'b1;
      else if (!push && do_pop) occ_q <= occ_q - 1'b1;
    end
  end

  // The arbiter's read credit must keep this from ever overflowing.
  assert property (@(posedge clk) disable iff (reset)
                   !(push && occ_q == OCC_W'(OUT_BUF_DEPTH)));

endmodule

// File: rtl/mc_drain_arbiter.sv
// Drains NUM_CH channel FIFOs in round-robin bursts of up to MAX_BURST words
// onto one valid/ready stream tagged with source channel and end-of-burst.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mc_drain_arbiter_if.master (FIFO read side + output stream)
// Reads are only issued while buffered + in-flight words leave room in the
// output buffer, so a stalled sink never loses a word.
module mc_drain_arbiter
  import drain_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  mc_drain_arbiter_if.master  bus
);

  localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [CW-1:0]         chan;
    logic                  last;
  } out_word_t;

  state_t        state_q, state_d;
  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] sel_q, sel_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          infl_valid_q, infl_last_q;
  logic [CW-1:0] infl_chan_q;

  logic [MAX_CH-1:0] req;
  logic [NUM_CH-1:0] rd_en;
  logic              issue, issue_last, credit_ok;
  logic [OCC_W-1:0]  buf_occ;
  logic              buf_valid;
  out_word_t         push_word, head_word;

  assign credit_ok = (buf_occ + OCC_W'(infl_valid_q)) < OCC_W'(OUT_BUF_DEPTH);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    sel_d       = sel_q;
    burst_cnt_d = burst_cnt_q;
    rd_en       = '0;
    issue       = 1'b0;
    issue_last  = 1'b0;
    req         = '0;
    req[NUM_CH-1:0] = ~bus.ch_empty;

    case (state_q)
      ARB: begin
        if (|req) begin
          sel_d       = CW'(rr_next(32'(rr_ptr_q), req, NUM_CH));
          burst_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (!bus.ch_empty[sel_q]) begin
          if (credit_ok) begin
            issue        = 1'b1;
            rd_en[sel_q] = 1'b1;
            burst_cnt_d  = burst_cnt_q + 1'b1;
            // usedw==1 means this read empties the channel: close the burst.
            issue_last   = (burst_cnt_q == BW'(MAX_BURST - 1)) ||
                           (bus.ch_usedw[int'(sel_q)*UW +: UW] == UW'(1));
            if (issue_last) begin
              state_d  = ARB;
              rr_ptr_d = (sel_q == CW'(NUM_CH - 1)) ? '0 : sel_q + 1'b1;
            end
          end
        end else begin
          // Channel drained under us (another reader): abandon without m_last.
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      sel_q        <= '0;
      burst_cnt_q  <= '0;
      infl_valid_q <= 1'b0;
      infl_chan_q  <= '0;
      infl_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_q        <= sel_d;
      burst_cnt_q  <= burst_cnt_d;
      infl_valid_q <= issue;
      infl_chan_q  <= sel_q;
      infl_last_q  <= issue_last;
    end
  end

  // FIFO data_out is valid the cycle after rd_en; capture it with its tag.
  always_comb begin
    push_word      = '0;
    push_word.data = bus.ch_data[int'(infl_chan_q)*DATA_WIDTH +: DATA_WIDTH];
    push_word.chan = infl_chan_q;
    push_word.last = infl_last_q;
  end

  drain_out_buf #(
    .WIDTH($bits(out_word_t))
  ) u_out_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (infl_valid_q),
    .push_word(push_word),
    .pop      (bus.m_ready),
    .occ      (buf_occ),
    .valid    (buf_valid),
    .head     (head_word)
  );

  assign bus.ch_rd_en = rd_en;
  assign bus.m_valid  = buf_valid;
  assign bus.m_data   = head_word.data;
  assign bus.m_chan   = head_word.chan;
  assign bus.m_last   = head_word.last;

endmodule
